// File: rtl/ones_comp_checksum_check_pkg.sv
// Shared definitions for the ones'-complement checksum datapath:
// FSM state encoding, default sizing and the all-ones (negative zero) value.
package ones_comp_checksum_check_pkg;

    localparam int unsigned DEF_WIDTH     = 4;
    localparam int unsigned DEF_MAX_WORDS = 15;

    localparam logic [DEF_WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

endpackage

// File: rtl/ones_comp_add_fold.sv
// Combinational ones'-complement adder: WIDTH+1-bit sum with one end-around
// carry fold (a single fold always suffices, F+F folds to F).
module ones_comp_add_fold
    import ones_comp_checksum_check_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sum = raw[WIDTH-1:0] + WIDTH'(raw[WIDTH]);
    end

endmodule

// File: rtl/ones_comp_checksum_check.sv
// Receive-side checksum checker: folds a valid/ready word stream into a
// ones'-complement sum and reports pass/len_err one cycle after the last word.
module ones_comp_checksum_check
    import ones_comp_checksum_check_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             done,
    output logic             pass,
    output logic             len_err,
    output logic [WIDTH-1:0] sum_out
);

    localparam int unsigned       CW       = $clog2(MAX_WORDS + 2);
    localparam logic [CW-1:0]     CNT_SAT  = CW'(MAX_WORDS + 1);
    localparam logic [WIDTH-1:0]  ALL_ONES = '1;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             accept;
    logic             bad_len;

    assign accept = in_valid && in_ready;

    always_comb begin
        add_a      = (state == ACCUM) ? acc : '0;
        count_next = (state == IDLE) ? CW'(1) :
                     (count == CNT_SAT) ? count : count + CW'(1);
        bad_len    = (count_next < CW'(2)) || (count_next > CW'(MAX_WORDS));
    end

    ones_comp_add_fold #(.WIDTH(WIDTH)) u_add_fold (
        .a   (add_a),
        .b   (in_data),
        .sum (acc_next)
    );

    // Result registers load on the edge accepting the last word, so they are
    // already valid during the REPORT cycle in which done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            len_err  <= 1'b0;
            sum_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        acc   <= acc_next;
                        count <= count_next;
                        state <= ACCUM;
                        if (in_last) begin
                            state    <= REPORT;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            sum_out  <= acc_next;
                            len_err  <= bad_len;
                            pass     <= (acc_next == ALL_ONES) && !bad_len;
                        end
                    end
                end
                REPORT: begin
                    acc      <= '0;
                    count    <= '0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ones_comp_checksum_check.sv
// Directed bench for ones_comp_checksum_check: hand-computed packet sums,
// length boundaries, back-to-back handshake and asynchronous reset.
module tb_ones_comp_checksum_check;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       done;
    logic       pass;
    logic       len_err;
    logic [3:0] sum_out;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    ones_comp_checksum_check #(.WIDTH(4), .MAX_WORDS(15)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .done     (done),
        .pass     (pass),
        .len_err  (len_err),
        .sum_out  (sum_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Present one word at a negedge and hold it until the handshake edge;
    // returns at the negedge after acceptance with the number of stall cycles.
    task automatic send(input logic [3:0] d, input logic last, output int stalls);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        stalls   = 0;
        while (in_ready !== 1'b1 && stalls < 20) begin
            @(negedge clk);
            stalls++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_handshake: in_ready=%b required 1 within 20 cycles", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, done, pass, len_err, sum_out} !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: {rdy,done,pass,lerr,sum}=%b required 00000000",
                     {in_ready, done, pass, len_err, sum_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({in_ready, done} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release: {rdy,done}=%b required 10", {in_ready, done});
        end
    endtask

    task automatic test_basic;
        int s;
        send(4'h3, 1'b0, s);
        send(4'h5, 1'b0, s);
        send(4'h7, 1'b1, s);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b110, 4'hF}) begin
            fails++;
            $display("FAIL basic_result: {done,pass,lerr,sum}=%b required 110_1111",
                     {done, pass, len_err, sum_out});
        end
        @(negedge clk);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b010, 4'hF}) begin
            fails++;
            $display("FAIL basic_hold: {done,pass,lerr,sum}=%b required 010_1111",
                     {done, pass, len_err, sum_out});
        end
    endtask

    task automatic test_carry;
        int s;
        send(4'hF, 1'b0, s);
        send(4'h1, 1'b0, s);
        send(4'hE, 1'b1, s);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b110, 4'hF}) begin
            fails++;
            $display("FAIL carry_result: {done,pass,lerr,sum}=%b required 110_1111",
                     {done, pass, len_err, sum_out});
        end
        @(negedge clk);
        // F + 1 alone exposes the intermediate folded value
        send(4'hF, 1'b0, s);
        send(4'h1, 1'b1, s);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b100, 4'h1}) begin
            fails++;
            $display("FAIL carry_fold: {done,pass,lerr,sum}=%b required 100_0001",
                     {done, pass, len_err, sum_out});
        end
        @(negedge clk);
    endtask

    task automatic test_corrupt;
        int s;
        send(4'h3, 1'b0, s);
        send(4'h5, 1'b0, s);
        send(4'h6, 1'b1, s);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b100, 4'hE}) begin
            fails++;
            $display("FAIL corrupt_result: {done,pass,lerr,sum}=%b required 100_1110",
                     {done, pass, len_err, sum_out});
        end
        @(negedge clk);
    endtask

    task automatic test_length;
        int s;
        send(4'h5, 1'b0, s);
        send(4'hA, 1'b1, s);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b110, 4'hF}) begin
            fails++;
            $display("FAIL len_min2: {done,pass,lerr,sum}=%b required 110_1111",
                     {done, pass, len_err, sum_out});
        end
        @(negedge clk);
        send(4'hF, 1'b1, s);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b101, 4'hF}) begin
            fails++;
            $display("FAIL len_single: {done,pass,lerr,sum}=%b required 101_1111",
                     {done, pass, len_err, sum_out});
        end
        @(negedge clk);
        for (int i = 0; i < 14; i++) send(4'h0, 1'b0, s);
        send(4'hF, 1'b1, s);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b110, 4'hF}) begin
            fails++;
            $display("FAIL len_max15: {done,pass,lerr,sum}=%b required 110_1111",
                     {done, pass, len_err, sum_out});
        end
        @(negedge clk);
        for (int i = 0; i < 15; i++) send(4'h0, 1'b0, s);
        send(4'hF, 1'b1, s);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b101, 4'hF}) begin
            fails++;
            $display("FAIL len_over16: {done,pass,lerr,sum}=%b required 101_1111",
                     {done, pass, len_err, sum_out});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int s;
        int c0;
        c0 = done_cnt;
        send(4'h3, 1'b0, s);
        send(4'h5, 1'b0, s);
        send(4'h7, 1'b1, s);
        tests++;
        if ({done, in_ready, pass, sum_out} !== {3'b101, 4'hF}) begin
            fails++;
            $display("FAIL b2b_a_report: {done,rdy,pass,sum}=%b required 101_1111",
                     {done, in_ready, pass, sum_out});
        end
        send(4'h2, 1'b0, s);
        tests++;
        if (s !== 1) begin
            fails++;
            $display("FAIL b2b_bubble: stall cycles=%0d required 1", s);
        end
        send(4'h4, 1'b0, s);
        tests++;
        if (s !== 0) begin
            fails++;
            $display("FAIL b2b_stream: stall cycles=%0d required 0", s);
        end
        send(4'h9, 1'b1, s);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b110, 4'hF}) begin
            fails++;
            $display("FAIL b2b_b_result: {done,pass,lerr,sum}=%b required 110_1111",
                     {done, pass, len_err, sum_out});
        end
        @(negedge clk);
        tests++;
        if (done_cnt - c0 !== 2) begin
            fails++;
            $display("FAIL b2b_done_pulses: count=%0d required 2", done_cnt - c0);
        end
    endtask

    task automatic test_async_reset;
        int s;
        int c0;
        send(4'h3, 1'b0, s);
        send(4'h5, 1'b0, s);
        #2 rst_n = 1'b0;
        #1;
        c0 = done_cnt;
        tests++;
        if ({in_ready, done, pass, len_err, sum_out} !== 8'h00) begin
            fails++;
            $display("FAIL async_reset_clear: {rdy,done,pass,lerr,sum}=%b required 00000000",
                     {in_ready, done, pass, len_err, sum_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt !== c0) begin
            fails++;
            $display("FAIL async_reset_no_done: pulses=%0d required 0", done_cnt - c0);
        end
        send(4'h3, 1'b0, s);
        send(4'h5, 1'b0, s);
        send(4'h7, 1'b1, s);
        tests++;
        if ({done, pass, len_err, sum_out} !== {3'b110, 4'hF}) begin
            fails++;
            $display("FAIL async_reset_next: {done,pass,lerr,sum}=%b required 110_1111",
                     {done, pass, len_err, sum_out});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_corrupt();
        test_length();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
